// File: rtl/enc_cw16_serializer.sv
// enc_cw16_serializer: packs an 11-bit data word and its 5-bit parity field
// into a 16-bit codeword and shifts it out one bit per clock, with frame
// start/end flags and a one-word holding buffer for back-to-back streaming.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   en                  1: shifter advances, 0: stall (state frozen)
//   in_valid, in_ready  input word handshake (in_ready = hold empty)
//   data_in, parity_in  data word and its parity field
//   ser_out, ser_valid  serial codeword bit and its qualifier
//   frame_start/end     first / last bit of a frame (gated by ser_valid)
//   busy                shifter or holding buffer occupied
//   frame_cnt           completed frames, wraps at 16 bits
module enc_cw16_serializer #(
   parameter int DATA_W     = 11,
   parameter int PAR_W      = 5,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int GAP_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic [PAR_W-1:0]  parity_in,
   output logic              ser_out,
   output logic              ser_valid,
   output logic              frame_start,
   output logic              frame_end,
   output logic              busy,
   output logic [15:0]       frame_cnt
);

   localparam int CW_W = DATA_W + PAR_W;
   localparam logic [3:0] LAST = 4'd15;
   localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t          state, state_n;
   logic [CW_W-1:0] hold;
   logic [CW_W-1:0] shifter, shifter_n;
   logic            hold_full, hold_full_n;
   logic [3:0]      bit_cnt, bit_cnt_n;
   logic [3:0]      gap_cnt, gap_cnt_n;
   logic            ser_out_n, valid_n;
   logic            start_n, end_n, busy_n;
   logic            load, accept, frame_done;

   function automatic logic first_bit(input logic [CW_W-1:0] w);
      return MSB_FIRST ? w[CW_W-1] : w[0];
   endfunction

   // Shifter keeps only the bits not yet sent, next bit at the send end.
   function automatic logic [CW_W-1:0] advance(input logic [CW_W-1:0] w);
      return MSB_FIRST ? (w << 1) : (w >> 1);
   endfunction

   assign in_ready = !hold_full;
   assign accept   = in_valid && !hold_full;

   always_comb begin
      state_n    = state;
      shifter_n  = shifter;
      bit_cnt_n  = bit_cnt;
      gap_cnt_n  = gap_cnt;
      ser_out_n  = ser_out;
      valid_n    = 1'b0;
      start_n    = 1'b0;
      end_n      = 1'b0;
      load       = 1'b0;
      frame_done = 1'b0;
      if (en) begin
         unique case (state)
            IDLE: begin
               if (hold_full) load = 1'b1;
            end
            SHIFT: begin
               if (bit_cnt == LAST) begin
                  frame_done = 1'b1;
                  if (GAP_CYCLES > 0) begin
                     state_n   = GAP;
                     gap_cnt_n = 4'd0;
                  end else if (hold_full) begin
                     load = 1'b1;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  bit_cnt_n = bit_cnt + 4'd1;
                  ser_out_n = first_bit(shifter);
                  shifter_n = advance(shifter);
                  valid_n   = 1'b1;
                  end_n     = (bit_cnt == LAST - 4'd1);
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (hold_full) load = 1'b1;
                  else state_n = IDLE;
               end else begin
                  gap_cnt_n = gap_cnt + 4'd1;
               end
            end
            default: state_n = IDLE;
         endcase
         // Loading also presents bit 0, giving one-cycle handshake latency.
         if (load) begin
            state_n   = SHIFT;
            ser_out_n = first_bit(hold);
            shifter_n = advance(hold);
            bit_cnt_n = 4'd0;
            valid_n   = 1'b1;
            start_n   = 1'b1;
         end
      end
      hold_full_n = load ? 1'b0 : (accept ? 1'b1 : hold_full);
      busy_n      = (state_n != IDLE) || hold_full_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         hold        <= '0;
         hold_full   <= 1'b0;
         shifter     <= '0;
         bit_cnt     <= 4'd0;
         gap_cnt     <= 4'd0;
         ser_out     <= 1'b0;
         ser_valid   <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         hold_full   <= hold_full_n;
         shifter     <= shifter_n;
         bit_cnt     <= bit_cnt_n;
         gap_cnt     <= gap_cnt_n;
         ser_out     <= ser_out_n;
         ser_valid   <= valid_n;
         frame_start <= start_n;
         frame_end   <= end_n;
         busy        <= busy_n;
         if (accept) hold <= {data_in, parity_in};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame_cnt <= 16'd0;
      else if (frame_done) frame_cnt <= frame_cnt + 16'd1;
   end

endmodule

// File: tb/tb_enc_cw16_serializer.sv
// tb_enc_cw16_serializer: scoreboard bench for enc_cw16_serializer, one
// instance MSB-first without gap, one LSB-first with a 2-cycle gap.
module tb_enc_cw16_serializer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        iv [2];
   logic [10:0] din [2];
   logic [4:0]  pin [2];
   logic        rdy [2];
   logic        so [2];
   logic        sv [2];
   logic        fs [2];
   logic        fe [2];
   logic        bz [2];
   logic [15:0] fc [2];

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic b;
      logic s;
      logic f;
   } exp_t;

   exp_t        q0 [$];
   exp_t        q1 [$];
   logic [15:0] rx [2];
   int          run [2];
   int          run_max [2];
   int          idle [2];
   int          last_gap [2];
   int          mfc [2];
   bit          rand_on;

   always #5 clk = ~clk;

   enc_cw16_serializer u0 (
      .clk(clk), .rst_n(rst_n), .en(en),
      .in_valid(iv[0]), .in_ready(rdy[0]),
      .data_in(din[0]), .parity_in(pin[0]),
      .ser_out(so[0]), .ser_valid(sv[0]),
      .frame_start(fs[0]), .frame_end(fe[0]),
      .busy(bz[0]), .frame_cnt(fc[0])
   );

   enc_cw16_serializer #(.MSB_FIRST(1'b0), .GAP_CYCLES(2)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en),
      .in_valid(iv[1]), .in_ready(rdy[1]),
      .data_in(din[1]), .parity_in(pin[1]),
      .ser_out(so[1]), .ser_valid(sv[1]),
      .frame_start(fs[1]), .frame_end(fe[1]),
      .busy(bz[1]), .frame_cnt(fc[1])
   );

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   // Reference: bit i of the serial frame, straight from the codeword.
   function automatic logic model_bit(input logic [15:0] cw, input int i,
                                      input bit msb);
      return msb ? cw[15 - i] : cw[i];
   endfunction

   task automatic push_word(input int k, input logic [10:0] d,
                            input logic [4:0] p);
      logic [15:0] cw;
      exp_t        e;
      cw = {d, p};
      for (int i = 0; i < 16; i++) begin
         e.b = model_bit(cw, i, k == 0);
         e.s = (i == 0);
         e.f = (i == 15);
         if (k == 0) q0.push_back(e);
         else q1.push_back(e);
      end
      mfc[k]++;
   endtask

   task automatic send(input int k, input logic [10:0] d,
                       input logic [4:0] p);
      int t;
      t = 0;
      @(negedge clk);
      while (!rdy[k] && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!rdy[k]) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout u%0d: in_ready stuck 0", k);
         return;
      end
      iv[k] = 1'b1;
      din[k] = d;
      pin[k] = p;
      push_word(k, d, p);
      @(negedge clk);
      iv[k] = 1'b0;
      din[k] = 11'($urandom);
      pin[k] = 5'($urandom);
   endtask

   task automatic mon(input int k);
      exp_t e;
      int   n;
      if (!rst_n) return;
      if (sv[k]) begin
         run[k]++;
         if (run[k] > run_max[k]) run_max[k] = run[k];
         if (fs[k]) last_gap[k] = idle[k];
         n = (k == 0) ? q0.size() : q1.size();
         if (n == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL u%0d_extra_bit: got valid bit, want none", k);
         end else begin
            if (k == 0) e = q0.pop_front();
            else e = q1.pop_front();
            check($sformatf("u%0d_bit", k), {29'd0, so[k], fs[k], fe[k]},
                  {29'd0, e.b, e.s, e.f});
         end
         if (k == 0) rx[k] = {rx[k][14:0], so[k]};
         else rx[k] = {so[k], rx[k][15:1]};
         if (fe[k]) idle[k] = 0;
      end else begin
         run[k] = 0;
         idle[k]++;
         check($sformatf("u%0d_idle_flags", k), {30'd0, fs[k], fe[k]}, 0);
      end
   endtask

   always @(negedge clk) mon(0);
   always @(negedge clk) mon(1);

   task automatic drain(input string nm);
      int t;
      t = 0;
      while ((q0.size() != 0 || q1.size() != 0 || bz[0] || bz[1]) &&
             t < 3000) begin
         @(negedge clk);
         t++;
      end
      check({nm, "_drain"}, {31'd0, t < 3000}, 1);
      @(negedge clk);
   endtask

   task automatic wait_start(input int k);
      int t;
      t = 0;
      while (!fs[k] && t < 40) begin
         @(negedge clk);
         t++;
      end
      check($sformatf("u%0d_start_seen", k), {31'd0, fs[k]}, 1);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         iv[k] = 1'b0;
         din[k] = '0;
         pin[k] = '0;
         rx[k] = '0;
         run[k] = 0;
         run_max[k] = 0;
         idle[k] = 0;
         last_gap[k] = 0;
         mfc[k] = 0;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      en = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("rst_ready", {31'd0, rdy[k]}, 1);
         check("rst_valid", {31'd0, sv[k]}, 0);
         check("rst_busy", {31'd0, bz[k]}, 0);
         check("rst_cnt", {16'd0, fc[k]}, 0);
      end

      send(0, 11'h5A5, 5'h13);
      drain("single");
      check("single_rx", {16'd0, rx[0]}, 32'hB4B3);
      check("single_cnt", {16'd0, fc[0]}, 1);

      run_max[0] = 0;
      send(0, 11'h7FF, 5'h1F);
      send(0, 11'h000, 5'h00);
      check("b2b_ready_low", {31'd0, rdy[0]}, 0);
      check("b2b_busy", {31'd0, bz[0]}, 1);
      drain("b2b");
      check("b2b_run", run_max[0], 32);
      check("b2b_rx", {16'd0, rx[0]}, 0);
      check("b2b_cnt", {16'd0, fc[0]}, 3);

      send(0, 11'h52E, 5'h03);
      wait_start(0);
      repeat (7) @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_valid", {31'd0, sv[0]}, 0);
      end
      en = 1'b1;
      drain("stall");
      check("stall_rx", {16'd0, rx[0]}, 32'hA5C3);

      send(1, 11'h7FF, 5'h00);
      send(1, 11'h5A5, 5'h13);
      drain("gap");
      check("gap_len", last_gap[1], 2);
      check("gap_rx_lsb", {16'd0, rx[1]}, 32'hB4B3);
      check("gap_cnt", {16'd0, fc[1]}, 2);

      force u0.frame_cnt = 16'hFFFF;
      @(negedge clk);
      release u0.frame_cnt;
      mfc[0] = 32'hFFFF;
      send(0, 11'($urandom), 5'($urandom));
      drain("wrap");
      check("wrap_cnt", {16'd0, fc[0]}, 0);
      check("wrap_model", {16'd0, fc[0]}, {16'd0, 16'(mfc[0])});

      send(0, 11'($urandom), 5'($urandom));
      wait_start(0);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check("arst_ready", {31'd0, rdy[k]}, 1);
         check("arst_outs", {27'd0, so[k], sv[k], fs[k], fe[k], bz[k]}, 0);
         check("arst_cnt", {16'd0, fc[k]}, 0);
      end
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
         mfc[k] = 0;
         run[k] = 0;
         idle[k] = 0;
      end
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_cnt", {16'd0, fc[0]}, 0);
      check("post_rst_busy", {31'd0, bz[0]}, 0);

      rand_on = 1'b1;
      fork
         begin
            while (rand_on) begin
               @(negedge clk);
               en = ($urandom_range(0, 4) != 0);
            end
            en = 1'b1;
         end
         begin
            fork
               repeat (40) begin
                  repeat ($urandom_range(0, 18)) @(negedge clk);
                  send(0, 11'($urandom), 5'($urandom));
               end
               repeat (40) begin
                  repeat ($urandom_range(0, 18)) @(negedge clk);
                  send(1, 11'($urandom), 5'($urandom));
               end
            join
            rand_on = 1'b0;
         end
      join
      drain("random");
      for (int k = 0; k < 2; k++) begin
         check("rand_cnt", {16'd0, fc[k]}, {16'd0, 16'(mfc[k])});
         check("rand_ready", {31'd0, rdy[k]}, 1);
         check("rand_busy", {31'd0, bz[k]}, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
